mem_map_responder: RTL

MEM_MAP_RESPONDER -- requirements
Module: mem_map_responder

---
 rtl/mem_map_responder.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/mem_map_responder.sv
// Memory-mapped responder for a single-cycle core: a word RAM, a GPIO register, a free-running
// cycle counter, and a byte TX FIFO with a sticky overflow flag, all in one 512-byte window.
module mem_map_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h1001_0000,
  parameter int unsigned RAM_WORDS  = 64,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemWrite,
  input  logic [31:0] RamAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [7:0]  GPIO_out,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int unsigned RAM_AW = $clog2(RAM_WORDS);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_GPIO,
    SEL_CYCLE,
    SEL_TXDATA,
    SEL_STATUS
  } sel_e;

  sel_e              sel;
  logic [5:0]        word_idx;
  logic [RAM_AW-1:0] ram_idx;
  logic              unused_addr_bits;

  assign word_idx         = RamAdr[7:2];
  assign ram_idx          = RamAdr[RAM_AW+1:2];
  assign unused_addr_bits = ^RamAdr[1:0];

  // Address decode: only the upper 23 bits select the window; RAM may be smaller than its slot.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    sel = SEL_NONE;
    if (RamAdr[31:9] == BASE_ADDR[31:9]) begin
      if (!RamAdr[8]) begin
        if ({26'h0, word_idx} < RAM_WORDS) sel = SEL_RAM;
      end else begin
        case (word_idx)
          6'h00:   sel = SEL_GPIO;
          6'h01:   sel = SEL_CYCLE;
          6'h02:   sel = SEL_TXDATA;
          6'h03:   sel = SEL_STATUS;
          default: sel = SEL_NONE;
        endcase
      end
    end
  end

  logic wr_ram, wr_gpio, wr_cycle, push, wr_status;

  assign wr_ram    = MemWrite && (sel == SEL_RAM);
  assign wr_gpio   = MemWrite && (sel == SEL_GPIO);
  assign wr_cycle  = MemWrite && (sel == SEL_CYCLE);
  assign push      = MemWrite && (sel == SEL_TXDATA);
  assign wr_status = MemWrite && (sel == SEL_STATUS);

  // Storage arrays
  logic [31:0] ram_q  [RAM_WORDS];
  logic [7:0]  fifo_q [FIFO_DEPTH];

  // Architectural state
  logic [7:0]       gpio_q,     gpio_d;
  logic [31:0]      cycle_q,    cycle_d;
  logic [PTR_W-1:0] head_q,     head_d;
  logic [PTR_W-1:0] tail_q,     tail_d;
  logic [CNT_W-1:0] count_q,    count_d;
  logic             overflow_q, overflow_d;

  logic full, empty, pop, push_ok, ovf_event;

  assign full      = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign pop       = !empty && tx_ready;
  // A push into a full FIFO is still accepted when the head leaves on the same edge.
  assign push_ok   = push && (!full || pop);
  assign ovf_event = push && full && !pop;

  always_comb begin
    gpio_d     = gpio_q;
    cycle_d    = cycle_q + 32'd1;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q + CNT_W'(push_ok) - CNT_W'(pop);
    overflow_d = overflow_q;

    if (wr_gpio)  gpio_d  = WriteData[7:0];
    if (wr_cycle) cycle_d = WriteData;
    if (pop)      head_d  = head_q + PTR_W'(1);
    if (push_ok)  tail_d  = tail_q + PTR_W'(1);

    if (ovf_event)                  overflow_d = 1'b1;
    if (wr_status && WriteData[2])  overflow_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignments so every update sees pre-edge values.
    if (rst) begin
      gpio_q     <= '0;
      cycle_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      gpio_q     <= gpio_d;
      cycle_q    <= cycle_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: the arrays are deliberately not reset; a reset port would stop them mapping onto
  // RAM macros, and RAM contents must survive rst anyway. Writes are still blocked during rst.
  always_ff @(posedge clk) begin
    if (!rst && wr_ram)  ram_q[ram_idx]  <= WriteData;
    if (!rst && push_ok) fifo_q[tail_q]  <= WriteData[7:0];
  end

  logic [5:0] status_cnt;
  assign status_cnt = 6'(count_q);

  always_comb begin
    ReadData = 32'h0;
    case (sel)
      SEL_RAM:    ReadData = ram_q[ram_idx];
      SEL_GPIO:   ReadData = {24'h0, gpio_q};
      SEL_CYCLE:  ReadData = cycle_q;
      SEL_STATUS: ReadData = {23'h0, status_cnt, overflow_q, empty, full};
      default:    ReadData = 32'h0;
    endcase
  end

  assign GPIO_out = gpio_q;
  assign tx_valid = !empty;
  // Gated so the stale head byte never shows while the FIFO is empty.
  assign tx_data  = empty ? 8'h00 : fifo_q[head_q];

endmodule
